dm_port_arbiter: RTL

- Sequences and shares the single synchronous-read data-memory port between two requesters: the CPU MEM stage (load/store with byte enables and a pre-shifted write word) and a DMA/bus master using a valid/ready handshake.
- Generates the pipeline stall for the CPU.
- Returns raw 32-bit read words; byte/half extension stays in the MEM-stage extension unit.

---
 rtl/dm_port_arbiter_if.sv | 57 +++++
 rtl/dm_port_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dm_port_arbiter_if
//
// Bundles the three buses around the data-memory port arbiter:
//   cpu_*  : MEM-stage load/store request, stall and load return word
//   dma_*  : DMA/bus-master valid/ready request and read return pulse
//   mem_*  : the single synchronous-read data-memory port
//
// Modports:
//   master : the surroundings (CPU MEM stage, DMA master, memory macro)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface dm_port_arbiter_if;

    // CPU MEM stage
    logic        cpu_req;
    logic [3:0]  cpu_byte_en;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    // DMA master
    logic        dma_valid;
    logic        dma_ready;
    logic [3:0]  dma_byte_en;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;

    // Data memory port
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output cpu_req, cpu_byte_en, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_valid, dma_byte_en, dma_addr, dma_wdata,
        input  dma_ready, dma_rvalid, dma_rdata,
        input  mem_en, mem_addr, mem_byte_en, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_byte_en, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_valid, dma_byte_en, dma_addr, dma_wdata,
        output dma_ready, dma_rvalid, dma_rdata,
        output mem_en, mem_addr, mem_byte_en, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/dm_port_arbiter.sv
// ---------------------------------------------------------------------------
// dm_port_arbiter
//
// Shares one synchronous-read data-memory port between the CPU MEM stage and
// a DMA master. Only the IDLE state issues; a read occupies the port for one
// extra "return" cycle (CPU_RD or DMA_RD) in which nothing is issued. Stores
// and DMA writes commit at the end of their issue cycle, so a CPU store never
// stalls the pipeline unless the DMA takes the port.
//
// The DMA normally yields to the CPU, but once it has been denied
// DMA_MAX_WAIT consecutive IDLE cycles it wins the next IDLE cycle.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-low; while low all combinational outputs
//           are forced to zero and any in-flight read is dropped
//   bus   : dm_port_arbiter_if.slave (cpu_*, dma_*, mem_* groups)
//
// Read words are returned raw; byte/half extension happens downstream.
// ---------------------------------------------------------------------------
module dm_port_arbiter #(
    parameter int unsigned DMA_MAX_WAIT = 4,
    parameter int unsigned CNT_W        = 3   // needs 2**CNT_W > DMA_MAX_WAIT
) (
    input  logic             clk,
    input  logic             reset,
    dm_port_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] MAX_WAIT = CNT_W'(DMA_MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CPU_RD = 2'd1,
        ST_DMA_RD = 2'd2
    } state_t;

    state_t           state_reg,      state_next;
    logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
    logic             dma_rvalid_reg, dma_rvalid_next;

    // Ungated versions of the combinational outputs; the reset gate is
    // applied in one place at the bottom of the module.
    logic        mem_en_int;
    logic [31:0] mem_addr_int;
    logic [3:0]  mem_byte_en_int;
    logic [31:0] mem_wdata_int;
    logic        dma_ready_int;
    logic        cpu_stall_int;
    logic [31:0] cpu_rdata_int;
    logic [31:0] dma_rdata_int;

    // Request decode, only acted upon in IDLE.
    logic cpu_is_store;
    logic dma_is_write;
    logic dma_win;

    assign cpu_is_store = |bus.cpu_byte_en;
    assign dma_is_write = |bus.dma_byte_en;

    // DMA takes the port when the CPU has nothing to do, or when it has
    // waited long enough. With DMA_MAX_WAIT == 0 the counter test is always
    // true, giving the DMA unconditional priority.
    assign dma_win = bus.dma_valid &&
                     ((starve_cnt_reg >= MAX_WAIT) || !bus.cpu_req);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            starve_cnt_reg <= '0;
            dma_rvalid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            dma_rvalid_reg <= dma_rvalid_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next      = ST_IDLE;
        starve_cnt_next = starve_cnt_reg;
        dma_rvalid_next = 1'b0;

        mem_en_int      = 1'b0;
        mem_addr_int    = '0;
        mem_byte_en_int = '0;
        mem_wdata_int   = '0;
        dma_ready_int   = 1'b0;
        cpu_stall_int   = 1'b0;
        cpu_rdata_int   = '0;
        dma_rdata_int   = '0;

        case (state_reg)
            ST_IDLE: begin
                if (dma_win) begin
                    dma_ready_int   = 1'b1;
                    mem_en_int      = 1'b1;
                    mem_addr_int    = bus.dma_addr;
                    mem_byte_en_int = bus.dma_byte_en;
                    mem_wdata_int   = dma_is_write ? bus.dma_wdata : '0;
                    // The CPU loses the port, so any CPU access must wait.
                    cpu_stall_int   = bus.cpu_req;
                    starve_cnt_next = '0;
                    if (!dma_is_write) begin
                        state_next      = ST_DMA_RD;
                        dma_rvalid_next = 1'b1;
                    end
                end else if (bus.cpu_req) begin
                    mem_en_int      = 1'b1;
                    mem_addr_int    = bus.cpu_addr;
                    mem_byte_en_int = bus.cpu_byte_en;
                    if (cpu_is_store) begin
                        mem_wdata_int = bus.cpu_wdata;
                    end else begin
                        // Load: hold the pipeline until the data returns.
                        cpu_stall_int = 1'b1;
                        state_next    = ST_CPU_RD;
                    end
                    if (bus.dma_valid && (starve_cnt_reg < MAX_WAIT)) begin
                        starve_cnt_next = starve_cnt_reg + CNT_W'(1);
                    end
                end
            end

            // The load is still presented by the frozen MEM stage here; it
            // is completed, not re-issued, and the pipeline is released.
            ST_CPU_RD: begin
                cpu_rdata_int = bus.mem_rdata;
            end

            ST_DMA_RD: begin
                dma_rdata_int = bus.mem_rdata;
                cpu_stall_int = bus.cpu_req;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs, all forced to zero while reset is held low. dma_rvalid is
    // gated as well so a read cut short by reset never reports data.
    // -----------------------------------------------------------------------
    assign bus.mem_en      = reset & mem_en_int;
    assign bus.mem_addr    = reset ? mem_addr_int    : '0;
    assign bus.mem_byte_en = reset ? mem_byte_en_int : '0;
    assign bus.mem_wdata   = reset ? mem_wdata_int   : '0;
    assign bus.dma_ready   = reset & dma_ready_int;
    assign bus.cpu_stall   = reset & cpu_stall_int;
    assign bus.cpu_rdata   = reset ? cpu_rdata_int   : '0;
    assign bus.dma_rvalid  = reset & dma_rvalid_reg;
    assign bus.dma_rdata   = (reset && dma_rvalid_reg) ? dma_rdata_int : '0;

    // -----------------------------------------------------------------------
    // Structural invariants
    // -----------------------------------------------------------------------
    // A DMA acceptance always coincides with a memory access.
    a_ready_has_access: assert property (
        @(posedge clk) bus.dma_ready |-> bus.mem_en);

    // Return cycles never issue anything.
    a_no_issue_in_return: assert property (
        @(posedge clk) disable iff (!reset)
        (state_reg != ST_IDLE) |-> !bus.mem_en);

    // The starvation counter saturates at the threshold.
    a_starve_bounded: assert property (
        @(posedge clk) disable iff (!reset)
        starve_cnt_reg <= MAX_WAIT);

    // Read data for the DMA is a single-cycle pulse.
    a_rvalid_pulse: assert property (
        @(posedge clk) disable iff (!reset)
        bus.dma_rvalid |=> !bus.dma_rvalid);

endmodule
